// File: rtl/t_flip_flop_bank.sv
// Bank of WIDTH independent toggle flip-flops with a complemented output,
// a one-cycle "changed" pulse and a wrapping count of toggle events.
// With WIDTH=1 this is the basic T flip-flop cell for dividers and counters.
module t_flip_flop_bank #(
   parameter int               WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
   parameter int               CNT_WIDTH   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     t,
   output logic [WIDTH-1:0]     q,
   output logic [WIDTH-1:0]     q_n,
   output logic                 changed,
   output logic [CNT_WIDTH-1:0] toggle_cnt
);

   logic [WIDTH-1:0]     q_q;
   logic [WIDTH-1:0]     q_d;
   logic                 changed_q;
   logic                 changed_d;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;
   logic                 any_toggle;

   // Each bit inverts only when its own toggle request is set.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign q_d[gi] = q_q[gi] ^ t[gi];
   end

   assign any_toggle = |t;

   // Status next-state: pulse on any toggle, count edges that toggled something.
   always_comb begin
      changed_d = any_toggle;
      cnt_d     = cnt_q;
      if (any_toggle) begin
         cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   // State registers; reset is asynchronous and overrides any clock edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q       <= RESET_VALUE;
         changed_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         q_q       <= q_d;
         changed_q <= changed_d;
         cnt_q     <= cnt_d;
      end
   end

   assign q          = q_q;
   assign q_n        = ~q_q;
   assign changed    = changed_q;
   assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_t_flip_flop_bank.sv
// Directed bench for t_flip_flop_bank: four instances cover the single-bit
// cell, a 4-bit bank, a non-zero reset value and a 2-bit wrapping counter.
module tb_t_flip_flop_bank;

   logic clk    = 1'b0;
   logic clk_en = 1'b0;
   logic rst    = 1'b1;

   logic       t1;
   logic       q1, qn1, ch1;
   logic [7:0] cnt1;

   logic [3:0] t4;
   logic [3:0] q4, qn4;
   logic       ch4;
   logic [7:0] cnt4;

   logic [3:0] qr, qnr;
   logic       chr;
   logic [7:0] cntr;

   logic       tw;
   logic       qw, qnw, chw;
   logic [1:0] cntw;

   int checks_cnt = 0;
   int errors_cnt = 0;

   t_flip_flop_bank #(.WIDTH(1), .RESET_VALUE(1'b0), .CNT_WIDTH(8)) dut1 (
      .clk(clk), .rst(rst), .t(t1), .q(q1), .q_n(qn1),
      .changed(ch1), .toggle_cnt(cnt1));

   t_flip_flop_bank #(.WIDTH(4), .RESET_VALUE(4'b0000), .CNT_WIDTH(8)) dut4 (
      .clk(clk), .rst(rst), .t(t4), .q(q4), .q_n(qn4),
      .changed(ch4), .toggle_cnt(cnt4));

   t_flip_flop_bank #(.WIDTH(4), .RESET_VALUE(4'b1001), .CNT_WIDTH(8)) dutr (
      .clk(clk), .rst(rst), .t(t4), .q(qr), .q_n(qnr),
      .changed(chr), .toggle_cnt(cntr));

   t_flip_flop_bank #(.WIDTH(1), .RESET_VALUE(1'b0), .CNT_WIDTH(2)) dutw (
      .clk(clk), .rst(rst), .t(tw), .q(qw), .q_n(qnw),
      .changed(chw), .toggle_cnt(cntw));

   // Clock runs only while enabled so reset can be checked with clk stopped.
   always #5 clk = clk_en ? ~clk : 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   // One rising edge, then settle to the falling edge for sampling/driving.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      t1 = 1'b0; t4 = 4'b0000; tw = 1'b0;

      // Asynchronous reset with the clock stopped.
      #2 rst = 1'b0;
      #1;
      check("rst_q1",   32'(q1),   32'h0);
      check("rst_qn1",  32'(qn1),  32'h1);
      check("rst_ch1",  32'(ch1),  32'h0);
      check("rst_cnt1", 32'(cnt1), 32'h0);
      check("rst_q4",   32'(q4),   32'h0);
      check("rst_qn4",  32'(qn4),  32'hF);
      check("rst_qr",   32'(qr),   32'h9);
      check("rst_qnr",  32'(qnr),  32'h6);
      check("rst_cntw", 32'(cntw), 32'h0);

      // Edges while reset is held are ignored.
      t1 = 1'b1; t4 = 4'b1111;
      clk_en = 1'b1;
      tick(); tick();
      check("held_q1",  32'(q1),   32'h0);
      check("held_cnt", 32'(cnt1), 32'h0);
      check("held_qr",  32'(qr),   32'h9);
      t1 = 1'b0; t4 = 4'b0000;
      #2 rst = 1'b1;

      // Hold: t=0 for five edges.
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("hold%0d_q1", i),   32'(q1),   32'h0);
         check($sformatf("hold%0d_ch1", i),  32'(ch1),  32'h0);
         check($sformatf("hold%0d_cnt1", i), 32'(cnt1), 32'h0);
      end
      check("hold_qr", 32'(qr), 32'h9);

      // Toggle: single bit with t=1 for six edges.
      t1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("tog%0d_q1", i),   32'(q1),   (i % 2 == 0) ? 32'h1 : 32'h0);
         check($sformatf("tog%0d_qn1", i),  32'(qn1),  (i % 2 == 0) ? 32'h0 : 32'h1);
         check($sformatf("tog%0d_ch1", i),  32'(ch1),  32'h1);
         check($sformatf("tog%0d_cnt1", i), 32'(cnt1), 32'(i + 1));
      end
      t1 = 1'b0;
      tick();
      check("tog_end_ch1",  32'(ch1),  32'h0);
      check("tog_end_cnt1", 32'(cnt1), 32'h6);
      check("tog_end_q1",   32'(q1),   32'h0);

      // t pulse between edges is not sampled.
      t1 = 1'b1;
      #2 t1 = 1'b0;
      tick();
      check("glitch_q1",   32'(q1),   32'h0);
      check("glitch_cnt1", 32'(cnt1), 32'h6);

      // Mixed bits on the 4-bit banks.
      t4 = 4'b0101;
      tick();
      check("mix1_q4",  32'(q4),   32'h5);
      check("mix1_qn4", 32'(qn4),  32'hA);
      check("mix1_ch4", 32'(ch4),  32'h1);
      check("mix1_qr",  32'(qr),   32'hC);
      t4 = 4'b0011;
      tick();
      check("mix2_q4",   32'(q4),   32'h6);
      check("mix2_qn4",  32'(qn4),  32'h9);
      check("mix2_cnt4", 32'(cnt4), 32'h2);
      check("mix2_qr",   32'(qr),   32'hF);
      check("mix2_cntr", 32'(cntr), 32'h2);
      t4 = 4'b0000;
      tick();
      check("mix3_q4",   32'(q4),   32'h6);
      check("mix3_ch4",  32'(ch4),  32'h0);
      check("mix3_cnt4", 32'(cnt4), 32'h2);

      // Counter wrap on the 2-bit counter instance.
      tw = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("wrap%0d_cntw", i), 32'(cntw), 32'((i + 1) % 4));
         check($sformatf("wrap%0d_qw", i),   32'(qw),   (i % 2 == 0) ? 32'h1 : 32'h0);
      end
      tw = 1'b0;

      // Reset mid-operation, asserted between edges.
      t1 = 1'b1;
      tick();
      check("mid_pre_q1",   32'(q1),   32'h1);
      check("mid_pre_cnt1", 32'(cnt1), 32'h7);
      #1 rst = 1'b0;
      #1;
      check("mid_rst_q1",   32'(q1),   32'h0);
      check("mid_rst_qn1",  32'(qn1),  32'h1);
      check("mid_rst_cnt1", 32'(cnt1), 32'h0);
      check("mid_rst_ch1",  32'(ch1),  32'h0);
      check("mid_rst_qr",   32'(qr),   32'h9);
      check("mid_rst_cntw", 32'(cntw), 32'h0);
      #1 rst = 1'b1;
      tick();
      check("mid_rel_q1",   32'(q1),   32'h1);
      check("mid_rel_cnt1", 32'(cnt1), 32'h1);
      check("mid_rel_ch1",  32'(ch1),  32'h1);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule

// File: doc/t_flip_flop_bank.md
Name: t_flip_flop_bank

Overview:
- Parameterizable bank of WIDTH independent T (toggle) flip-flops sharing one clock and one reset.
- Each bit of q inverts on a rising clock edge when its t bit is 1, and holds when its t bit is 0.
- Also provides a complemented output, a one-cycle "changed" flag and a running toggle-event counter for debug/status use.
- With WIDTH=1 it is the basic single T flip-flop leaf cell used in counters and frequency dividers.

Parameters:
- WIDTH, 1, number of independent toggle bits.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q while reset is asserted.
- CNT_WIDTH, 8, width of the toggle-event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- t  input  WIDTH  per-bit toggle request; 1 = invert that q bit on the next clk rising edge.
- q  output  WIDTH  registered state.
- q_n  output  WIDTH  bitwise complement of q (combinational from q).
- changed  output  1  registered; high for exactly one cycle after any clk edge on which at least one q bit toggled.
- toggle_cnt  output  CNT_WIDTH  number of clk edges on which at least one q bit toggled; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset: rst=0 forces immediately, without waiting for a clock edge:
  - q = RESET_VALUE, q_n = ~RESET_VALUE
  - changed = 0, toggle_cnt = 0
  - Reset held: clk edges are ignored and outputs stay at their reset values.
- Reset release: rst rising is asynchronous; the first active edge is the first clk rising edge with rst=1. No toggle occurs on release itself.
- Normal operation (rst=1), each clk rising edge:
  - q <= q ^ t (per bit; latency 1 cycle).
  - changed <= |t.
  - toggle_cnt <= toggle_cnt + 1 if |t, else holds; it wraps from all-ones to 0.
- Hold: t=0 keeps q unchanged indefinitely, changed=0, and the counter holds.
- Continuous t=1: q divides clk by 2, giving a period of 2 clk cycles and a 50% duty cycle.
- Changes on t between clk edges have no effect; only the value sampled at the rising edge matters.
- Reset mid-operation: rst falling at any time, including coincident with a clk edge, takes priority and clears all state asynchronously.
- Bits are fully independent; a mixed t vector toggles only the selected bits.
- q_n always equals ~q, including during reset.
- No X handling is required beyond standard RTL semantics; the bench must drive t to a known value before releasing reset.

Test Plan:
- Async reset: with rst=0 and clk stopped, drive q arbitrarily beforehand; expect q=0, q_n=1, changed=0, toggle_cnt=0 immediately, before any clk edge.
- Hold: rst=1, t=0 for 5 edges after reset -> q stays 0, changed=0, toggle_cnt=0.
- Toggle: WIDTH=1, t=1 for 6 edges -> q sequence 1,0,1,0,1,0; changed=1 each cycle; toggle_cnt=6.
- Mixed bits: WIDTH=4, q=0000, apply t=0101 for one edge -> q=0101; then t=0011 -> q=0110; q_n=1001; toggle_cnt=2.
- Reset mid-operation: while toggling with q=1, assert rst=0 between edges -> q=0 and toggle_cnt=0 instantly; release rst with t=1 -> q=1 on the next edge.
- Counter wrap: CNT_WIDTH=2, t=1 for 5 edges -> toggle_cnt sequence 1,2,3,0,1.
